// File: rtl/dec_arbiter_if.sv
// Request/grant bundle between four requesters and the decoder arbiter.
// master drives requests and line codes; slave returns grant and decoder lines.
interface dec_arbiter_if;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic        en;
    logic [15:0] D;
    logic [3:0]  done;
    logic        busy;

    modport master (
        output req, code,
        input  gnt, sel, en, D, done, busy
    );

    modport slave (
        input  req, code,
        output gnt, sel, en, D, done, busy
    );
endinterface

// File: rtl/dec_arbiter.sv
// Round-robin arbiter driving a 4-to-16 decoder; one grant is held HOLD_CYCLES, then one GAP cycle.
// Grant appears 1 cycle after req is sampled in IDLE; req is ignored while busy, with no stall path back.
module dec_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    dec_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [3:0] HOLD_M1  = 4'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        en_q, en_d;
    logic [15:0] d_q, d_d;
    logic [3:0]  done_q, done_d;
    logic        busy_q, busy_d;

    logic        found;
    logic [1:0]  pick_idx;
    logic [1:0]  idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        idx      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        d_d     = d_q;
        done_d  = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = 4'd1 << pick_idx;
                    sel_d   = bus.code[{pick_idx, 2'b00} +: 4];
                    en_d    = 1'b1;
                    d_d     = 16'd1 << sel_d;
                    ptr_d   = pick_idx + 2'd1;
                    cnt_d   = HOLD_M1;
                    done_d  = (HOLD_M1 == 4'd0) ? gnt_d : 4'd0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // cnt_q counts ACTIVE cycles still to come after this one.
                if (cnt_q == 4'd0) begin
                    state_d = S_GAP;
                    gnt_d   = 4'd0;
                    en_d    = 1'b0;
                    d_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        done_d = gnt_q;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'd0;
            sel_q   <= 4'd0;
            en_q    <= 1'b0;
            d_q     <= 16'd0;
            done_q  <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            d_q     <= d_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.D    = d_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_dec_arbiter.sv
// Directed bench for dec_arbiter with HOLD_CYCLES=2 and hand-computed expectations.
module tb_dec_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dec_arbiter_if bus ();

    dec_arbiter #(.HOLD_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] gnt, input logic [3:0] sel,
                           input logic en, input logic [15:0] d, input logic [3:0] done,
                           input logic busy);
        chk({tag, ".gnt"},  32'(bus.gnt),  32'(gnt));
        chk({tag, ".sel"},  32'(bus.sel),  32'(sel));
        chk({tag, ".en"},   32'(bus.en),   32'(en));
        chk({tag, ".D"},    32'(bus.D),    32'(d));
        chk({tag, ".done"}, 32'(bus.done), 32'(done));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    endtask

    // Line codes per requester: 0->1, 1->5, 2->8, 3->C
    logic [15:0] base_code;
    logic [3:0]  exp_sel [4];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        base_code    = 16'hC851;
        exp_sel[0]   = 4'h1;
        exp_sel[1]   = 4'h5;
        exp_sel[2]   = 4'h8;
        exp_sel[3]   = 4'hC;

        // Reset held two cycles with all requesting
        rst      = 1'b1;
        bus.req  = 4'hF;
        bus.code = base_code;
        tick();
        chk_all("rst1", 4'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b0);
        tick();
        chk_all("rst2", 4'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b0);
        rst = 1'b0;

        // All requesting: order 0,1,2,3,0 spaced 4 cycles
        for (int g = 0; g < 5; g++) begin
            tick();
            chk_all($sformatf("rr%0d.a1", g), 4'd1 << (g % 4), exp_sel[g % 4], 1'b1,
                    16'd1 << exp_sel[g % 4], 4'd0, 1'b1);
            tick();
            chk_all($sformatf("rr%0d.a2", g), 4'd1 << (g % 4), exp_sel[g % 4], 1'b1,
                    16'd1 << exp_sel[g % 4], 4'd1 << (g % 4), 1'b1);
            tick();
            chk_all($sformatf("rr%0d.gap", g), 4'd0, exp_sel[g % 4], 1'b0, 16'd0, 4'd0, 1'b1);
            tick();
            chk_all($sformatf("rr%0d.idle", g), 4'd0, exp_sel[g % 4], 1'b0, 16'd0, 4'd0, 1'b0);
            if (g == 4) bus.req = 4'd0;
        end
        tick();
        chk("idle_noreq.gnt", 32'(bus.gnt), 32'd0);

        // Pointer priority: grant 1, then req=1001 must pick 3 before 0
        bus.req = 4'b0010;
        tick();
        chk("pp_g1.gnt", 32'(bus.gnt), 32'h2);
        bus.req = 4'd0;
        tick(); tick(); tick();
        bus.req = 4'b1001;
        tick();
        chk_all("pp_g3", 4'b1000, 4'hC, 1'b1, 16'h1000, 4'd0, 1'b1);
        tick(); tick(); tick();
        tick();
        chk("pp_g0.gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'd0;
        tick(); tick(); tick();

        // Single request, code[11:8]=A
        bus.code = 16'hCA51;
        bus.req  = 4'b0100;
        tick();
        chk_all("single.a1", 4'b0100, 4'hA, 1'b1, 16'h0400, 4'd0, 1'b1);
        bus.req = 4'd0;
        tick();
        chk_all("single.a2", 4'b0100, 4'hA, 1'b1, 16'h0400, 4'b0100, 1'b1);
        tick();
        chk_all("single.gap", 4'd0, 4'hA, 1'b0, 16'd0, 4'd0, 1'b1);
        tick();
        chk_all("single.idle", 4'd0, 4'hA, 1'b0, 16'd0, 4'd0, 1'b0);

        // Mid-hold: drop req and scramble code during ACTIVE
        bus.code = base_code;
        bus.req  = 4'b0010;
        tick();
        chk_all("mid.a1", 4'b0010, 4'h5, 1'b1, 16'h0020, 4'd0, 1'b1);
        bus.req  = 4'd0;
        bus.code = 16'hFFFF;
        tick();
        chk_all("mid.a2", 4'b0010, 4'h5, 1'b1, 16'h0020, 4'b0010, 1'b1);
        tick();
        chk_all("mid.gap", 4'd0, 4'h5, 1'b0, 16'd0, 4'd0, 1'b1);
        tick();

        // Reset in first ACTIVE cycle: ptr is 2 here, so grant goes to 2 first
        bus.code = base_code;
        bus.req  = 4'hF;
        tick();
        chk_all("rsta.a1", 4'b0100, 4'h8, 1'b1, 16'h0100, 4'd0, 1'b1);
        rst = 1'b1;
        tick();
        chk_all("rsta.rst", 4'd0, 4'd0, 1'b0, 16'd0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("rsta.g0", 4'b0001, 4'h1, 1'b1, 16'h0002, 4'd0, 1'b1);
        tick();
        chk("rsta.done", 32'(bus.done), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dec_arbiter.md
DEC_ARBITER -- requirements
Module: dec_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, meaning the number of cycles a granted decoder line stays active (legal 1..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  4  request per requester i (0..3).
REQ-005 SHALL have port code  input  16  requester i's 4-bit line address, in code[4i+3:4i].
REQ-006 SHALL have port gnt  output  4  one-hot grant, 0 when no grant.
REQ-007 SHALL have port sel  output  4  decoder select {X,Y,Z,W}, sel[3]=X is the MSB.
REQ-008 SHALL have port en  output  1  decoder enable.
REQ-009 SHALL have port D  output  16  decoded line: D[sel]=1 when en=1, else all zero.
REQ-010 SHALL have port done  output  4  one-cycle pulse to requester i at the end of its hold.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL register all outputs; no combinational path from req or code to any output.
REQ-013 SHALL implement the FSM states IDLE, ACTIVE and GAP.
REQ-014 SHALL, in IDLE with any req bit set, grant by round-robin starting at pointer ptr (2 bits), searching ptr, ptr+1, ... mod 4.
REQ-015 SHALL, on a grant to requester i, on the same edge: set gnt[i]=1, capture sel=code[4i+3:4i], set en=1, set D=one-hot(sel), set ptr=(i+1) mod 4, load the hold counter and enter ACTIVE.
REQ-016 SHALL give a latency of 1 cycle from req sampled high in IDLE to gnt, sel, en and D valid.
REQ-017 SHALL hold gnt, sel, en and D stable for exactly HOLD_CYCLES cycles in ACTIVE; sel SHALL NOT follow changes on code after capture.
REQ-018 SHALL pulse done[i] high during the last ACTIVE cycle of requester i's grant only.
REQ-019 SHALL, after the last ACTIVE cycle, enter GAP for exactly 1 cycle with gnt=0, en=0, D=0 and sel holding its last value (break-before-make).
REQ-020 SHALL go from GAP to IDLE unconditionally; IDLE SHALL sample requests, so back-to-back grants are spaced HOLD_CYCLES+2 cycles apart.
REQ-021 SHALL ignore req in ACTIVE and GAP; a requester dropping req mid-hold SHALL NOT abort the hold, and done SHALL still pulse.
REQ-022 SHALL handle simultaneous requests by round-robin only, with no starvation: a continuously asserted request is granted within 4 grant periods.
REQ-023 SHALL keep HOLD_CYCLES=1 legal: exactly one ACTIVE cycle, with done asserted in it.
REQ-024 SHALL keep gnt at most one-hot and D at most one-hot at all times.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state=IDLE, ptr=0, gnt=0, sel=0, en=0, D=0, done=0, busy=0 and clear the hold counter.
REQ-026 SHALL let rst override every state including mid-ACTIVE: no done pulse for the aborted grant, and ptr is reset to 0.
REQ-027 SHALL sample requests no earlier than the first edge after rst deasserts.

Verification
REQ-028 SHALL cover reset: hold rst 2 cycles with req=4'hF -> all outputs 0 throughout; the first grant after release goes to requester 0.
REQ-029 SHALL cover a single request (HOLD_CYCLES=2): req=4'b0100, code[11:8]=4'hA -> next cycle gnt=4'b0100, sel=4'hA, en=1, D=16'h0400 for 2 cycles; done=4'b0100 in the 2nd cycle; then 1 GAP cycle with D=0.
REQ-030 SHALL cover all requesting: req=4'hF held from reset -> grant order 0,1,2,3,0 with grant starts spaced 4 cycles apart.
REQ-031 SHALL cover pointer priority: after a grant to 1, req=4'b1001 in IDLE -> requester 3 is granted before 0.
REQ-032 SHALL cover a mid-hold change: during ACTIVE drop req and change code -> sel and D unchanged, full hold length, done still pulses.
REQ-033 SHALL cover reset mid-ACTIVE: assert rst in the 1st ACTIVE cycle -> next cycle all outputs 0, no done, and the next grant from req=4'hF goes to 0.
